cp0_exc_ctrl: RTL

- Sequencer and arbiter for the CP0 register file's single write/read port.
- Sequences exception and interrupt entry as writes to EPC (14), Cause (13) and Status (12), one per cycle.
- Sequences ERET as a read of EPC, a Status restore and a PC redirect.
- Arbitrates these sequences against MTC0 writes and MFC0 reads from the pipeline; stalls the pipeline while a sequence runs.

---
 rtl/cp0_pkg.sv | 39 +++
 rtl/cp0_int_detect.sv | 28 ++
 rtl/cp0_exc_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions and sequencer states.
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 10;
    localparam int ST_IM_HI  = 15;
    localparam int CA_IP_LO  = 10;
    localparam int CA_IP_HI  = 15;
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;

    localparam logic [1:0] WEN_WRITE = 2'b11;
    localparam logic [1:0] WEN_NONE  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STATUS,
        R_EPC,
        E_STATUS,
        REDIRECT
    } cp0_state_t;

    // Cause image: IP in 15:10, ExcCode in 6:2, every other bit zero.
    function automatic logic [31:0] make_cause(input logic [5:0] ip, input logic [4:0] code);
        logic [31:0] c;
        c = '0;
        c[CA_IP_HI:CA_IP_LO]   = ip;
        c[CA_EXC_HI:CA_EXC_LO] = code;
        return c;
    endfunction

endpackage

// File: rtl/cp0_int_detect.sv
// Registers the hardware interrupt lines and qualifies them against IE/EXL/IM.
module cp0_int_detect
    import cp0_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_hw_int,
    input  logic       i_ie,
    input  logic       i_exl,
    input  logic [5:0] i_im,
    output logic [5:0] o_ip_q,
    output logic       o_int_pend
);

    logic [5:0] r_ip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ip <= '0;
        end else begin
            r_ip <= i_hw_int;
        end
    end

    assign o_ip_q     = r_ip;
    assign o_int_pend = i_ie & ~i_exl & (|(r_ip & i_im));

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Sequences exception/interrupt entry and ERET onto the single CP0 RF port,
// arbitrating against pipeline MTC0/MFC0 and stalling while a sequence runs.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] STATUS_RST = 32'h3000_0000,
    parameter logic [4:0]  INT_CODE   = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        eret_req,
    input  logic        mtc0_req,
    input  logic [4:0]  mtc0_reg,
    input  logic [31:0] mtc0_data,
    input  logic [4:0]  mfc0_reg,
    input  logic [31:0] cp0_rdata,
    output logic [1:0]  cp0_wen,
    output logic [4:0]  cp0_regnum,
    output logic [31:0] cp0_din,
    output logic [31:0] mfc0_data,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc
);

    cp0_state_t  r_state, w_state_next;
    logic [31:0] r_status, r_epc, r_pc;
    logic [4:0]  r_code;
    logic        r_eret;

    logic [5:0]  w_ip_q;
    logic        w_int_pend, w_take_exc;
    logic [1:0]  w_wen;
    logic [4:0]  w_regnum;
    logic [31:0] w_din, w_redirect_pc;
    logic        w_stall, w_redirect;

    cp0_int_detect u_int_detect (
        .clk        (clk),
        .rst        (rst),
        .i_hw_int   (hw_int),
        .i_ie       (r_status[ST_IE]),
        .i_exl      (r_status[ST_EXL]),
        .i_im       (r_status[ST_IM_HI:ST_IM_LO]),
        .o_ip_q     (w_ip_q),
        .o_int_pend (w_int_pend)
    );

    assign w_take_exc = (r_state == IDLE) && (w_int_pend || exc_req);

    always_comb begin
        w_state_next  = r_state;
        w_wen         = WEN_NONE;
        w_regnum      = mfc0_reg;
        w_din         = '0;
        w_stall       = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        case (r_state)
            IDLE: begin
                if (w_take_exc) begin
                    w_state_next = W_EPC;
                    w_stall      = 1'b1;
                end else if (eret_req) begin
                    w_state_next = R_EPC;
                    w_stall      = 1'b1;
                end else if (mtc0_req) begin
                    w_wen    = WEN_WRITE;
                    w_regnum = mtc0_reg;
                    w_din    = mtc0_data;
                end
            end
            W_EPC: begin
                w_wen        = WEN_WRITE;
                w_regnum     = CP0_EPC;
                w_din        = r_pc;
                w_stall      = 1'b1;
                w_state_next = W_CAUSE;
            end
            W_CAUSE: begin
                w_wen        = WEN_WRITE;
                w_regnum     = CP0_CAUSE;
                w_din        = make_cause(w_ip_q, r_code);
                w_stall      = 1'b1;
                w_state_next = W_STATUS;
            end
            W_STATUS: begin
                w_wen          = WEN_WRITE;
                w_regnum       = CP0_STATUS;
                w_din          = r_status;
                w_din[ST_EXL]  = 1'b1;
                w_stall        = 1'b1;
                w_state_next   = REDIRECT;
            end
            R_EPC: begin
                w_regnum     = CP0_EPC;
                w_stall      = 1'b1;
                w_state_next = E_STATUS;
            end
            E_STATUS: begin
                w_wen          = WEN_WRITE;
                w_regnum       = CP0_STATUS;
                w_din          = r_status;
                w_din[ST_EXL]  = 1'b0;
                w_stall        = 1'b1;
                w_state_next   = REDIRECT;
            end
            REDIRECT: begin
                w_redirect    = 1'b1;
                w_redirect_pc = r_eret ? r_epc : EXC_VECTOR;
                w_state_next  = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        // Outputs read as zero for the whole time reset is held, not just after the edge.
        if (rst) begin
            w_wen         = WEN_NONE;
            w_regnum      = '0;
            w_din         = '0;
            w_stall       = 1'b0;
            w_redirect    = 1'b0;
            w_redirect_pc = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_status <= STATUS_RST;
            r_epc    <= '0;
            r_pc     <= '0;
            r_code   <= '0;
            r_eret   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Shadow Status tracks every RF write to reg 12, whatever its source.
            if (w_wen == WEN_WRITE && w_regnum == CP0_STATUS) begin
                r_status <= w_din;
            end
            if (w_take_exc) begin
                r_code <= w_int_pend ? INT_CODE : exc_code;
                r_pc   <= exc_pc;
                r_eret <= 1'b0;
            end else if (r_state == IDLE && eret_req) begin
                r_eret <= 1'b1;
            end
            if (r_state == R_EPC) begin
                r_epc <= cp0_rdata;
            end
        end
    end

    assign cp0_wen     = w_wen;
    assign cp0_regnum  = w_regnum;
    assign cp0_din     = w_din;
    assign stall       = w_stall;
    assign pc_redirect = w_redirect;
    assign redirect_pc = w_redirect_pc;
    assign mfc0_data   = cp0_rdata;

endmodule
